// File: rtl/flit_pkg.sv
// flit_pkg -- shared definitions for the flit arbiter.
//   FLIT_W  : default flit width
//   LEN_LSB / LEN_W : location of the packet length field in a header flit
//   state_t : arbiter FSM states
//   eff_len : maps the raw header length field to a flit count (0 means 1)
package flit_pkg;

    localparam int FLIT_W  = 32;
    localparam int LEN_LSB = 0;
    localparam int LEN_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        POP  = 2'd2
    } state_t;

    // A zero length field still carries the header itself, so it counts as 1.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] raw);
        return (raw == '0) ? LEN_W'(1) : raw;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req   : request vector, one bit per port
//   ptr   : last served port; the search starts at ptr+1 and wraps
//   found : at least one request bit is set
//   idx   : first requesting port at or after ptr+1 (ptr itself is last)
module rr_pick
    import flit_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester overwrites earlier hits and ends up as the result.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/flit_arbiter.sv
// flit_arbiter -- wormhole round-robin arbiter forwarding packets from
// NUM_PORTS input flit buffers onto one output link.
//   clk, rst_n : clock, asynchronous active-low reset
//   rdy        : per-port "a complete packet is buffered"
//   flit_in    : per-port head flit, port i at [i*FLIT_W +: FLIT_W]
//   next       : one-cycle pop pulse to the granted buffer
//   out_valid / out_flit / out_last / out_ready : output link handshake
//   grant      : port currently owning the link
//   pkt_count  : completed packet counter (only with FLIT_ARB_STATS_EN)
// Optional feature macro: FLIT_ARB_STATS_EN
module flit_arbiter
    import flit_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int FLIT_W    = flit_pkg::FLIT_W,
    localparam int GW = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        rdy,
    input  logic [NUM_PORTS*FLIT_W-1:0] flit_in,
    output logic [NUM_PORTS-1:0]        next,
    output logic                        out_valid,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [GW-1:0]               grant
`ifdef FLIT_ARB_STATS_EN
   ,output logic [15:0]                 pkt_count
`endif
);

    state_t                          state, state_nx;
    logic [GW-1:0]                   rr_ptr;
    logic [LEN_W-1:0]                len, count;
    logic                            pick_found;
    logic [GW-1:0]                   pick_idx;
    logic [NUM_PORTS-1:0][FLIT_W-1:0] flits;
    logic [FLIT_W-1:0]               hdr;
    logic                            pkt_done;

    assign flits    = flit_in;
    assign hdr      = flits[pick_idx];
    // Leaving POP with every flit sent ends the packet.
    assign pkt_done = (state == POP) && (count >= len);

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .req   (rdy),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; rdy is only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_found) state_nx = XFER;
            XFER:    if (out_ready)  state_nx = POP;
            POP:     state_nx = (count < len) ? XFER : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant, length, flit count, round-robin pointer and the pop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant  <= '0;
            len    <= '0;
            count  <= '0;
            rr_ptr <= GW'(NUM_PORTS - 1);
            next   <= '0;
        end else begin
            next <= '0;
            case (state)
                IDLE: if (pick_found) begin
                    grant <= pick_idx;
                    len   <= eff_len(hdr[LEN_LSB +: LEN_W]);
                    count <= '0;
                end
                XFER: if (out_ready) begin
                    count <= count + LEN_W'(1);
                    next  <= NUM_PORTS'(1) << grant;
                end
                POP: if (pkt_done) rr_ptr <= grant;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        out_valid = (state == XFER);
        out_flit  = flits[grant];
        out_last  = (state == XFER) && (count == len - LEN_W'(1));
    end

`ifdef FLIT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pkt_count <= '0;
        else if (pkt_done) pkt_count <= pkt_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_flit_arbiter.sv
// tb_flit_arbiter -- directed bench for flit_arbiter with a behavioural
// buffer/link model and a per-cycle compare process.
module tb_flit_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   rdy, next;
    logic [NP*W-1:0] flit_in;
    logic            out_valid, out_last, out_ready;
    logic [W-1:0]    out_flit;
    logic [1:0]      grant;
`ifdef FLIT_ARB_STATS_EN
    logic [15:0]     pkt_count;
`endif

    always #5 clk = ~clk;

    flit_arbiter #(.NUM_PORTS(NP), .FLIT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdy       (rdy),
        .flit_in   (flit_in),
        .next      (next),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant)
`ifdef FLIT_ARB_STATS_EN
       ,.pkt_count (pkt_count)
`endif
    );

    // Input buffers: whole packets are pushed at once, so non-empty == rdy.
    logic [W-1:0] mem [NP][DEPTH];
    int hd [NP];
    int tl [NP];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NP; p++) hd[p] <= tl[p];   // abandon contents
        end else begin
            for (int p = 0; p < NP; p++) if (next[p]) hd[p] <= hd[p] + 1;
        end
    end

    always_comb begin
        rdy     = '0;
        flit_in = '0;
        for (int p = 0; p < NP; p++) begin
            rdy[p] = (hd[p] != tl[p]);
            flit_in[p*W +: W] = mem[p][hd[p] % DEPTH];
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input int n, input logic [W-1:0] header);
        for (int k = 0; k < n; k++)
            mem[p][(tl[p] + k) % DEPTH] = (k == 0) ? header : {8'(p), 8'(k), 16'hC0DE};
        tl[p] = tl[p] + n;
    endtask

    function automatic int rr_m(input int last, input logic [NP-1:0] r);
        for (int k = 1; k <= NP; k++)
            if (r[(last + k) % NP]) return (last + k) % NP;
        return -1;
    endfunction

    // Link model: who must own the link, which flit, which is last, and
    // exactly when each pop must happen.
    int last_o = NP - 1;
    int owner, idx, mlen, pend = -1, pkts, accs, lasts;
    bit in_pkt;
    int glog[$];
    int pops [NP];
    logic [W-1:0] exp_flit;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            last_o = NP - 1; pend = -1; in_pkt = 0; idx = 0; pkts = 0;
        end else begin
            chk("next_onehot", 64'($onehot0(next)), 64'd1);
            chk("next_pulse", 64'(next), (pend >= 0) ? 64'(1 << pend) : 64'd0);
            if (pend >= 0) begin
                chk("pop_gap", 64'(out_valid), 64'd0);
                pops[pend]++;
            end
            pend = -1;
            if (out_valid) begin
                if (!in_pkt) begin
                    owner = rr_m(last_o, rdy);
                    if (owner < 0) begin
                        checks++; fails++;
                        $display("FAIL spurious_valid: got out_valid=1 required 0 (no rdy)");
                    end else begin
                        exp_flit = mem[owner][hd[owner] % DEPTH];
                        mlen = (exp_flit[2:0] == 3'd0) ? 1 : int'(exp_flit[2:0]);
                        in_pkt = 1; idx = 0;
                    end
                end
                if (in_pkt) begin
                    exp_flit = mem[owner][hd[owner] % DEPTH];
                    chk("grant", 64'(grant), 64'(owner));
                    chk("out_flit", 64'(out_flit), 64'(exp_flit));
                    chk("out_last", 64'(out_last), 64'(idx == mlen - 1));
                    if (out_ready) begin
                        accs++;
                        if (out_last) lasts++;
                        idx++;
                        pend = owner;
                        if (idx == mlen) begin
                            in_pkt = 0; last_o = owner; pkts++; glog.push_back(owner);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            done = (rdy == '0) && !out_valid && (next == '0);
        end
        chk("idle_timeout", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int b_acc, b_last, b_pop, b_g;
    logic [W-1:0] held;
    bit seen;

    initial begin
        out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_next", 64'(next), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
`ifdef FLIT_ARB_STATS_EN
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
        @(negedge clk); rst_n = 1'b1;

        // Single len-3 packet on port 2
        @(negedge clk);
        b_acc = accs; b_last = lasts;
        push(2, 3, 32'h0000_A003);
        @(negedge clk); #1;
        chk("first_latency", 64'(out_valid), 64'd1);
        wait_idle(60);
        chk("p2_flits", 64'(accs - b_acc), 64'd3);
        chk("p2_lasts", 64'(lasts - b_last), 64'd1);
        chk("p2_pops", 64'(pops[2]), 64'd3);
        chk("p2_owner", 64'(glog[glog.size()-1]), 64'd2);

        // Alternation between ports 0 and 1 after reset
        reset_pulse();
        @(negedge clk);
        b_g = glog.size();
        push(0, 1, 32'h1000_0001); push(0, 1, 32'h1100_0001);
        push(1, 1, 32'h2000_0001); push(1, 1, 32'h2100_0001);
        wait_idle(80);
        chk("alt_count", 64'(glog.size() - b_g), 64'd4);
        if (glog.size() >= b_g + 4) begin
            chk("alt_g0", 64'(glog[b_g]),   64'd0);
            chk("alt_g1", 64'(glog[b_g+1]), 64'd1);
            chk("alt_g2", 64'(glog[b_g+2]), 64'd0);
            chk("alt_g3", 64'(glog[b_g+3]), 64'd1);
        end

        // Downstream stall for 10 cycles
        @(negedge clk);
        out_ready = 1'b0;
        b_acc = accs;
        push(3, 2, 32'h0000_5502);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk); #1;
            seen = out_valid;
        end
        chk("stall_start", 64'(seen), 64'd1);
        held = out_flit;
        chk("stall_hdr", 64'(held), 64'h0000_5502);
        repeat (10) begin
            @(negedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_flit", 64'(out_flit), 64'(held));
            chk("stall_next", 64'(next), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); #1;
        chk("stall_release_pop", 64'(next), 64'b1000);
        wait_idle(40);
        chk("stall_flits", 64'(accs - b_acc), 64'd2);

        // Zero length field means a single flit
        @(negedge clk);
        b_acc = accs; b_last = lasts;
        push(1, 1, 32'h0000_BEE0);
        wait_idle(40);
        chk("len0_flits", 64'(accs - b_acc), 64'd1);
        chk("len0_lasts", 64'(lasts - b_last), 64'd1);

        // Reset in the middle of a len-5 packet
        @(negedge clk);
        push(0, 1, 32'h0000_0001);          // make port 0 the last served
        wait_idle(40);
        @(negedge clk);
        push(1, 5, 32'h0000_7705);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #3;
            seen = next[1];
        end
        chk("reach_pop", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_next", 64'(next), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        b_pop = pops[1];
        repeat (4) @(negedge clk);
        chk("abandoned_pops", 64'(pops[1] - b_pop), 64'd0);
        b_g = glog.size();
        push(0, 1, 32'h3000_0001);
        push(1, 1, 32'h3100_0001);
        wait_idle(40);
        chk("post_rst_count", 64'(glog.size() - b_g), 64'd2);
        if (glog.size() >= b_g + 2) begin
            chk("post_rst_first", 64'(glog[b_g]),   64'd0);
            chk("post_rst_second", 64'(glog[b_g+1]), 64'd1);
        end
        @(negedge clk);
        push(2, 1, 32'h3200_0001);
        push(3, 2, 32'h3300_0002);
        wait_idle(60);
`ifdef FLIT_ARB_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

endmodule
